// File: rtl/panel_switch_reader.sv
// Scanner for a 74HC165 front-panel switch chain: loads the chain, shifts out
// 32 bits per frame, inverts the active-low switch bits and presents them as
// registered active-high outputs once per frame.
// Optional build macro PANEL_FILTER_EN: when defined, outputs only update after
// STABLE_FRAMES identical consecutive frames (bits 0-26); otherwise every frame.
module panel_switch_reader #(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned STABLE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        sh_ld_n,
  output logic        sh_clk,
  input  logic        sh_q,
  output logic [0:11] sr,
  output logic [0:5]  dsel,
  output logic        dep,
  output logic        sw,
  output logic        single_step,
  output logic        halt,
  output logic        exam,
  output logic        cont,
  output logic        extd_addr,
  output logic        addr_load,
  output logic        clear,
  output logic        frame_done
);

  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned NumBits = 27;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StLow, StHigh, StUpdate} state_e;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [4:0]           idx_q, idx_d;
  logic [NumBits-1:0]   raw_q, raw_d;   // active-high copy of the frame being shifted in
  logic [NumBits-1:0]   out_q;          // active-high output word, bit n = raw index n
  logic                 sh_ld_n_q, sh_clk_q, frame_done_q;
  logic                 div_done;
  logic                 load_out;

  assign div_done = (div_q == DivLast);

  // Next-state logic: divider, bit index and sample capture for the scan sequence
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    raw_d   = raw_q;
    unique case (state_q)
      StIdle: begin
        state_d = StLoad;
        div_d   = '0;
        idx_d   = '0;
      end
      StLoad: begin
        if (div_done) begin
          state_d = StLow;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLow: begin
        if (div_done) begin
          // Bits 27-31 are shifted through but never stored
          if (idx_q < 5'(NumBits)) raw_d[idx_q] = ~sh_q;
          state_d = (idx_q == 5'd31) ? StUpdate : StHigh;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHigh: begin
        if (div_done) begin
          idx_d   = idx_q + 5'd1;
          state_d = StLow;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

`ifdef PANEL_FILTER_EN
  localparam int unsigned CntW = $clog2(STABLE_FRAMES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_FRAMES - 1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NumBits-1:0] prev_q;
  logic               prev_valid_q;
  logic               match;

  // Match counter: counts consecutive identical frames, saturating at CntMax
  always_comb begin
    match = prev_valid_q && (raw_q == prev_q);
    cnt_d = '0;
    if (match) cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    load_out = (cnt_d == CntMax);
  end

  // Filter history updated once per completed frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (state_q == StUpdate) begin
      cnt_q        <= cnt_d;
      prev_q       <= raw_q;
      prev_valid_q <= 1'b1;
    end
  end
`else
  assign load_out = 1'b1;
`endif

  // State and registered pins; pins are derived from the next state so they are glitch-free
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      div_q        <= '0;
      idx_q        <= '0;
      raw_q        <= '0;
      out_q        <= '0;
      sh_ld_n_q    <= 1'b1;
      sh_clk_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      raw_q        <= raw_d;
      sh_ld_n_q    <= (state_d != StLoad);
      sh_clk_q     <= (state_d == StHigh);
      frame_done_q <= (state_q == StUpdate);
      if ((state_q == StUpdate) && load_out) out_q <= raw_q;
    end
  end

  // Map the output word onto the named switch ports
  always_comb begin
    for (int i = 0; i < 12; i++) sr[i] = out_q[i];
    for (int i = 0; i < 6; i++) dsel[i] = out_q[12 + i];
    dep         = out_q[18];
    sw          = out_q[19];
    single_step = out_q[20];
    halt        = out_q[21];
    exam        = out_q[22];
    cont        = out_q[23];
    extd_addr   = out_q[24];
    addr_load   = out_q[25];
    clear       = out_q[26];
  end

  assign sh_ld_n    = sh_ld_n_q;
  assign sh_clk     = sh_clk_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_panel_switch_reader.sv
// Directed bench for panel_switch_reader with a behavioural 74HC165 chain model.
// Expectations follow the filter setting of the build (PANEL_FILTER_EN).
module tb_panel_switch_reader;

  localparam int CD = 2;
  localparam int SF = 3;
`ifdef PANEL_FILTER_EN
  localparam int Need = SF;
`else
  localparam int Need = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sh_ld_n, sh_clk, sh_q;
  logic [0:11] sr;
  logic [0:5]  dsel;
  logic        dep, sw, single_step, halt, exam, cont, extd_addr, addr_load, clear;
  logic        frame_done;

  logic [31:0] pattern = '1;  // raw active-low chain contents, bit 0 shifted out first
  logic [31:0] chain = '1;
  logic        sh_clk_prev = 1'b0;
  logic [26:0] obs;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  panel_switch_reader #(.CLK_DIV(CD), .STABLE_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .sh_ld_n(sh_ld_n), .sh_clk(sh_clk), .sh_q(sh_q),
    .sr(sr), .dsel(dsel), .dep(dep), .sw(sw), .single_step(single_step), .halt(halt),
    .exam(exam), .cont(cont), .extd_addr(extd_addr), .addr_load(addr_load), .clear(clear),
    .frame_done(frame_done)
  );

  // Chain model: parallel load while sh_ld_n low, shift toward Q7 on sh_clk rise
  always @(posedge clk) begin
    sh_clk_prev <= sh_clk;
    if (!sh_ld_n) chain <= pattern;
    else if (sh_clk && !sh_clk_prev) chain <= {1'b1, chain[31:1]};
  end
  assign sh_q = chain[0];

  // Collect outputs into raw-index order
  always_comb begin
    obs = '0;
    for (int i = 0; i < 12; i++) obs[i] = sr[i];
    for (int i = 0; i < 6; i++) obs[12 + i] = dsel[i];
    obs[18] = dep;  obs[19] = sw;   obs[20] = single_step; obs[21] = halt;
    obs[22] = exam; obs[23] = cont; obs[24] = extd_addr;   obs[25] = addr_load;
    obs[26] = clear;
  end

  task automatic wait_fd();
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (!ok) $display("FAIL fd_timeout: got no frame_done, required one within 300 cycles");
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int c;
    pattern = '1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (sh_ld_n !== 1'b1 || sh_clk !== 1'b0 || frame_done !== 1'b0 || obs !== 27'd0)
      $display("FAIL reset_state: ld_n=%b clk=%b fd=%b outs=%h, required 1 0 0 0",
               sh_ld_n, sh_clk, frame_done, obs);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (sh_ld_n !== 1'b0) $display("FAIL load_start: sh_ld_n=%b, required 0", sh_ld_n);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (sh_ld_n !== 1'b0) $display("FAIL load_hold: sh_ld_n=%b, required 0", sh_ld_n);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (sh_ld_n !== 1'b1) $display("FAIL load_end: sh_ld_n=%b, required 1", sh_ld_n);
    else n_pass++;
    wait_fd();
    c = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      c++;
      if (frame_done) break;
    end
    n_total++;
    if (c != 130) $display("FAIL frame_period: got %0d cycles, required 130", c);
    else n_pass++;
    for (int k = 0; k < Need; k++) begin
      wait_fd();
      n_total++;
      if (obs !== 27'd0) $display("FAIL idle_outputs: got %h, required 0", obs);
      else n_pass++;
    end
  endtask

  task automatic test_stable();
    logic [26:0] e;
    do_reset();
    pattern = 32'hFFFF_F000;  // sr switches all on
    for (int k = 1; k <= Need + 1; k++) begin
      wait_fd();
      e = (k >= Need) ? 27'h000_0FFF : 27'd0;
      n_total++;
      if (obs !== e) $display("FAIL stable_sr frame %0d: got %h, required %h", k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [26:0] e;
    do_reset();
    pattern = ~(32'd1 << 22);  // exam on for frames 1-2 only
    for (int k = 1; k <= 6; k++) begin
      wait_fd();
      e = '0;
      if (Need == 1 && k <= 2) e[22] = 1'b1;
      n_total++;
      if (obs !== e) $display("FAIL glitch_exam frame %0d: got %h, required %h", k, obs, e);
      else n_pass++;
      if (k == 2) pattern = '1;
    end
  endtask

  task automatic test_reset_mid();
    logic [26:0] e;
    do_reset();
    pattern = ~(32'd1 << 26);  // clear switch on
    wait_fd();
    e = (Need == 1) ? (27'd1 << 26) : 27'd0;
    n_total++;
    if (obs !== e) $display("FAIL mid_first: got %h, required %h", obs, e);
    else n_pass++;
    repeat (60) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (sh_clk !== 1'b0 || sh_ld_n !== 1'b1 || obs !== 27'd0 || frame_done !== 1'b0)
      $display("FAIL mid_reset: clk=%b ld_n=%b fd=%b outs=%h, required 0 1 0 0",
               sh_clk, sh_ld_n, frame_done, obs);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= Need; k++) begin
      wait_fd();
      e = (k == Need) ? (27'd1 << 26) : 27'd0;
      n_total++;
      if (obs !== e) $display("FAIL mid_recover frame %0d: got %h, required %h", k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_ignore();
    logic [31:0] base;
    logic [26:0] e;
    base = ~((32'd1 << 5) | (32'd1 << 12) | (32'd1 << 18));  // sr[5], dsel[0], dep
    do_reset();
    for (int k = 1; k <= Need + 2; k++) begin
      pattern = (k % 2 == 1) ? (base & 32'h07FF_FFFF) : base;
      wait_fd();
      e = (k >= Need) ? 27'h004_1020 : 27'd0;
      n_total++;
      if (obs !== e) $display("FAIL ignore_hi frame %0d: got %h, required %h", k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] e;
    do_reset();
    pattern = ~((32'd1 << 0) | (32'd1 << 25));  // sr[0], addr_load
    for (int k = 1; k <= Need; k++) wait_fd();
    n_total++;
    if (obs !== 27'h200_0001) $display("FAIL b2b_first: got %h, required 2000001", obs);
    else n_pass++;
    pattern = ~((32'd1 << 11) | (32'd1 << 24));  // sr[11], extd_addr
    for (int k = 1; k <= Need; k++) begin
      wait_fd();
      e = (k < Need) ? 27'h200_0001 : 27'h100_0800;
      n_total++;
      if (obs !== e) $display("FAIL b2b_second frame %0d: got %h, required %h", k, obs, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_glitch();
    test_reset_mid();
    test_ignore();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
